// File: rtl/lock_pkg.sv
// Shared state encoding and default code constants for the password lock.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_e;

    localparam logic [15:0] DEF_PASSWORD  = 16'h1947;
    localparam int          DEF_MAX_FAILS = 3;

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that holds busy for CYCLES clocks after a start pulse.
module lockout_timer #(
    parameter logic [31:0] CYCLES = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    logic [31:0] cnt_q;
    logic        busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= (CYCLES == 32'd0) ? 32'd0 : CYCLES - 32'd1;
        end else if (busy_q) begin
            if (cnt_q == 32'd0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 32'd1;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == 32'd0);

endmodule

// File: rtl/password_lock_fsm.sv
// Digit-by-digit code lock; PASSWORD_LOCK_LOCKOUT_EN adds fail counting
// and a timed lockout after MAX_FAILS consecutive wrong codes.
module password_lock_fsm
    import lock_pkg::*;
#(
    parameter int                   DIGITS         = 4,
    parameter logic [4*DIGITS-1:0]  PASSWORD       = (4*DIGITS)'(DEF_PASSWORD),
    parameter int                   MAX_FAILS      = DEF_MAX_FAILS,
    parameter logic [31:0]          LOCKOUT_CYCLES = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_digit,
    input  logic       i_enter,
    input  logic       i_relock,
    output logic [3:0] hex,
    output logic       o_unlock,
    output logic       o_error,
    output logic       o_locked_out,
    output logic [3:0] o_count
);

    localparam int         W        = 4 * DIGITS;
    localparam logic [3:0] DIGITS_C = 4'(DIGITS);

    state_e         state_q;
    logic [W-1:0]   buf_q;
    logic [3:0]     hex_q;
    logic [3:0]     cnt_q;
    logic           unlock_q;
    logic           error_q;

    logic [W-1:0]   buf_d;
    logic [3:0]     cnt_d;
    logic           match;

    assign buf_d = (buf_q << 4) | W'(i_digit);
    assign cnt_d = cnt_q + 4'd1;
    assign match = (buf_q == PASSWORD);

`ifdef PASSWORD_LOCK_LOCKOUT_EN
    localparam logic [7:0] MAX_C = 8'(MAX_FAILS);

    logic [7:0] fails_q;
    logic [7:0] fails_d;
    logic       locked_q;
    logic       tmr_start;
    logic       tmr_busy;
    logic       tmr_done;

    assign fails_d   = (fails_q >= MAX_C) ? fails_q : fails_q + 8'd1;
    assign tmr_start = (state_q == ST_CHECK) && !match && (fails_d >= MAX_C);

    lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (tmr_start),
        .busy_o  (tmr_busy),
        .done_o  (tmr_done)
    );

    assign o_locked_out = locked_q;
`else
    logic unused_cfg;
    assign unused_cfg   = ^{MAX_FAILS, LOCKOUT_CYCLES};
    assign o_locked_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            hex_q    <= '0;
            cnt_q    <= '0;
            unlock_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef PASSWORD_LOCK_LOCKOUT_EN
            fails_q  <= '0;
            locked_q <= 1'b0;
`endif
        end else begin
            error_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (i_enter) begin
                        buf_q   <= buf_d;
                        hex_q   <= i_digit;
                        cnt_q   <= cnt_d;
                        state_q <= (cnt_d == DIGITS_C) ? ST_CHECK : ST_ENTRY;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        unlock_q <= 1'b1;
                        hex_q    <= '0;
                        state_q  <= ST_UNLOCKED;
`ifdef PASSWORD_LOCK_LOCKOUT_EN
                        fails_q  <= '0;
`endif
                    end else begin
                        error_q <= 1'b1;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        hex_q   <= '0;
                        state_q <= ST_IDLE;
`ifdef PASSWORD_LOCK_LOCKOUT_EN
                        fails_q <= fails_d;
                        if (fails_d >= MAX_C) begin
                            locked_q <= 1'b1;
                            state_q  <= ST_LOCKOUT;
                        end
`endif
                    end
                end
                ST_UNLOCKED: begin
                    if (i_relock) begin
                        unlock_q <= 1'b0;
                        buf_q    <= '0;
                        cnt_q    <= '0;
                        hex_q    <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
`ifdef PASSWORD_LOCK_LOCKOUT_EN
                ST_LOCKOUT: begin
                    // a stalled timer must never trap the lock
                    if (tmr_done || !tmr_busy) begin
                        locked_q <= 1'b0;
                        fails_q  <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hex      = hex_q;
    assign o_unlock = unlock_q;
    assign o_error  = error_q;
    assign o_count  = cnt_q;

endmodule

// File: doc/password_lock_fsm.md
PASSWORD_LOCK_FSM -- requirements
Module: password_lock_fsm

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of code digits (1..8).
REQ-002 SHALL have parameter PASSWORD, default 16'h1947, stored code, 4 bits per digit, first-entered digit in the most-significant nibble; width 4*DIGITS.
REQ-003 SHALL have parameter MAX_FAILS, default 3, consecutive failed attempts that trigger lockout.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 32'd50_000_000, lockout duration in clk cycles.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port i_digit, input, 4, switch value for the digit being entered.
REQ-008 SHALL have port i_enter, input, 1, debounced single-cycle strobe that accepts i_digit.
REQ-009 SHALL have port i_relock, input, 1, single-cycle strobe that relocks from UNLOCKED.
REQ-010 SHALL have port hex, output, 4, last accepted digit; feeds the seven-segment driver.
REQ-011 SHALL have port o_unlock, output, 1, registered; high while in UNLOCKED.
REQ-012 SHALL have port o_error, output, 1, one-cycle pulse on a mismatched code.
REQ-013 SHALL have port o_locked_out, output, 1, high while in LOCKOUT.
REQ-014 SHALL have port o_count, output, 4, digits accepted in the current attempt.

Function
REQ-015 SHALL implement states IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT.
REQ-016 SHALL, in IDLE or ENTRY, on i_enter: shift i_digit into the entry buffer, load hex with i_digit, increment o_count, and enter ENTRY.
REQ-017 SHALL enter CHECK on the edge that accepts digit number DIGITS; i_enter SHALL be ignored in CHECK.
REQ-018 SHALL, in CHECK on a match, set o_unlock high one cycle later, clear the fail counter, and enter UNLOCKED.
  - Latency: 2 edges from the final accepting edge.
REQ-019 SHALL, in CHECK on a mismatch:
  - pulse o_error for exactly one cycle;
  - increment the fail counter (saturating at MAX_FAILS);
  - clear the buffer, o_count and hex to 0;
  - go to IDLE.
REQ-020 SHALL ignore i_enter in UNLOCKED; i_relock SHALL clear o_unlock, buffer, o_count and hex, and go to IDLE.
REQ-021 SHALL ignore i_relock in every state except UNLOCKED.
REQ-022 SHALL give i_relock priority when i_enter and i_relock are asserted together in UNLOCKED.
REQ-023 SHALL keep hex at 0 while o_unlock is high.

Reset
REQ-024 SHALL, on rst, asynchronously force:
  - state IDLE;
  - hex, o_count and the buffer to 0;
  - o_unlock, o_error and o_locked_out to 0;
  - the fail and lockout counters to 0.
REQ-025 SHALL abandon any in-progress attempt, unlock or lockout on reset; an in-progress entry SHALL NOT count as a fail.

Configuration
REQ-026 SHALL compile the lockout feature only when macro PASSWORD_LOCK_LOCKOUT_EN is defined.
REQ-027 SHALL, with PASSWORD_LOCK_LOCKOUT_EN defined:
  - enter LOCKOUT from CHECK when a mismatch brings the fail count to MAX_FAILS;
  - in LOCKOUT, ignore i_enter, hold o_locked_out high, and count LOCKOUT_CYCLES;
  - at count end, clear the fail counter and go to IDLE.
REQ-028 SHALL, without PASSWORD_LOCK_LOCKOUT_EN: omit LOCKOUT, the fail and lockout counters; tie o_locked_out to 0; allow unlimited retries.

Structure
REQ-029 SHALL take the state enumeration and default PASSWORD/MAX_FAILS constants from a shared package, lock_pkg.
REQ-030 SHALL place the lockout timer in one sub-module, lockout_timer (start, busy, done), instantiated only under the macro.

Verification
REQ-031 SHALL cover: enter 1,9,4,7 -> o_unlock=1 two edges after the 4th i_enter; hex=0; o_error never asserted.
REQ-032 SHALL cover: enter 1,9,4,8 -> single-cycle o_error; o_count=0; o_unlock stays 0.
REQ-033 SHALL cover, with macro and LOCKOUT_CYCLES=10: three wrong codes -> o_locked_out high 10 cycles; i_enter ignored; then IDLE, and 1,9,4,7 unlocks.
REQ-034 SHALL cover: assert rst after 2 digits -> all outputs 0; a fresh 1,9,4,7 unlocks.
REQ-035 SHALL cover: i_enter and i_relock together in UNLOCKED -> o_unlock=0, o_count=0.
REQ-036 SHALL cover: i_enter on the cycle in CHECK -> ignored; o_count unchanged.
